// File: rtl/seizure_pkg.sv
// Shared types and constants for the seizure detector: FSM states, Q4.4 scaling and compare width.
package seizure_pkg;

  localparam int Q_FRAC_BITS    = 4;
  localparam int DEF_FEAT_WIDTH = 25;
  localparam int DEF_BASE_WIDTH = 37;
  localparam int DEF_MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    WARMUP,
    IDLE,
    PENDING,
    ALARM,
    CLEARING
  } state_e;

  // Full-precision width of base * multiplier, with one extra bit for the sign.
  function automatic int cmp_width(input int base_width, input int mult_width);
    return base_width + mult_width + 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/thresh_cmp.sv
// Registered scale-and-compare: exceed = (feat << 4) > (base * mult), full precision.
// One cycle from feat_vld_i to exceed_o/cmp_vld_o; no backpressure, accepts a sample every cycle.
module thresh_cmp
  import seizure_pkg::*;
#(
  parameter int FEAT_WIDTH  = DEF_FEAT_WIDTH,
  parameter int BASE_WIDTH  = DEF_BASE_WIDTH,
  parameter int MULT_WIDTH  = DEF_MULT_WIDTH,
  parameter int THRESH_MULT = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [FEAT_WIDTH-1:0] feat_i,
  input  logic                         feat_vld_i,
  input  logic signed [BASE_WIDTH-1:0] base_i,
  output logic                         exceed_o,
  output logic                         cmp_vld_o
);

  localparam int CW = cmp_width(BASE_WIDTH, MULT_WIDTH);
  localparam logic [MULT_WIDTH-1:0] MULT_Q   = MULT_WIDTH'(THRESH_MULT);
  localparam logic signed [CW-1:0]  MULT_EXT = signed'(CW'(MULT_Q));

  logic signed [CW-1:0] feat_ext, base_ext, lhs, rhs;
  logic exceed_q, exceed_d, cmp_vld_q;

  assign feat_ext = {{(CW-FEAT_WIDTH){feat_i[FEAT_WIDTH-1]}}, feat_i};
  assign base_ext = {{(CW-BASE_WIDTH){base_i[BASE_WIDTH-1]}}, base_i};
  // Feature is aligned to the Q4.4 multiplier so the compare needs no division.
  assign lhs      = feat_ext <<< Q_FRAC_BITS;
  assign rhs      = base_ext * MULT_EXT;
  assign exceed_d = feat_vld_i ? (lhs > rhs) : exceed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exceed_q  <= 1'b0;
      cmp_vld_q <= 1'b0;
    end else begin
      exceed_q  <= exceed_d;
      cmp_vld_q <= feat_vld_i;
    end
  end

  assign exceed_o  = exceed_q;
  assign cmp_vld_o = cmp_vld_q;

endmodule

// File: rtl/seizure_detector.sv
// Seizure alarm with onset/offset hysteresis over a floored baseline; seizure follows a sample by 2 edges, full rate.
// Optional onset counter on event_count when SEIZURE_EVENT_COUNT_EN is defined.
module seizure_detector
  import seizure_pkg::*;
#(
  parameter int FEAT_WIDTH   = DEF_FEAT_WIDTH,
  parameter int BASE_WIDTH   = DEF_BASE_WIDTH,
  parameter int MULT_WIDTH   = DEF_MULT_WIDTH,
  parameter int THRESH_MULT  = 48,
  parameter int BASE_FLOOR   = 16,
  parameter int ONSET_COUNT  = 4,
  parameter int OFFSET_COUNT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [FEAT_WIDTH-1:0] feat_in,
  input  logic                         feat_valid,
  input  logic signed [BASE_WIDTH-1:0] base_in,
  input  logic                         base_valid,
  output logic                         seizure,
  output logic                         exceed,
  output logic                         armed,
  output logic [15:0]                  event_count
);

  localparam logic signed [BASE_WIDTH-1:0] FLOOR = BASE_WIDTH'(BASE_FLOOR);
  localparam logic [7:0] ONSET_C  = 8'(ONSET_COUNT);
  localparam logic [7:0] OFFSET_C = 8'(OFFSET_COUNT);

  state_e                  state_q, state_d;
  logic [7:0]              on_run_q, on_run_d, off_run_q, off_run_d;
  logic signed [BASE_WIDTH-1:0] base_q, base_d;
  logic                    armed_q, armed_d, seizure_q, seizure_d;
  logic                    cmp_vld;

  // The compare reads base_q, so a coincident base update only affects later samples.
  thresh_cmp #(
    .FEAT_WIDTH (FEAT_WIDTH),
    .BASE_WIDTH (BASE_WIDTH),
    .MULT_WIDTH (MULT_WIDTH),
    .THRESH_MULT(THRESH_MULT)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .feat_i    (feat_in),
    .feat_vld_i(feat_valid),
    .base_i    (base_q),
    .exceed_o  (exceed),
    .cmp_vld_o (cmp_vld)
  );

  always_comb begin
    base_d  = base_q;
    armed_d = armed_q;
    if (base_valid) begin
      base_d  = (base_in < FLOOR) ? FLOOR : base_in;
      armed_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    on_run_d  = on_run_q;
    off_run_d = off_run_q;
    case (state_q)
      WARMUP: begin
        if (base_valid) state_d = IDLE;
      end
      IDLE: begin
        if (cmp_vld && exceed) begin
          on_run_d = 8'd1;
          state_d  = (ONSET_C == 8'd1) ? ALARM : PENDING;
        end
      end
      PENDING: begin
        if (cmp_vld) begin
          if (exceed) begin
            on_run_d = sat_inc8(on_run_q);
            if (on_run_d >= ONSET_C) state_d = ALARM;
          end else begin
            on_run_d = 8'd0;
            state_d  = IDLE;
          end
        end
      end
      ALARM: begin
        if (cmp_vld && !exceed) begin
          off_run_d = 8'd1;
          state_d   = (OFFSET_C == 8'd1) ? IDLE : CLEARING;
        end
      end
      CLEARING: begin
        if (cmp_vld) begin
          if (!exceed) begin
            off_run_d = sat_inc8(off_run_q);
            if (off_run_d >= OFFSET_C) state_d = IDLE;
          end else begin
            off_run_d = 8'd0;
            state_d   = ALARM;
          end
        end
      end
      default: state_d = WARMUP;
    endcase
    seizure_d = (state_d == ALARM) || (state_d == CLEARING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WARMUP;
      on_run_q  <= 8'd0;
      off_run_q <= 8'd0;
      base_q    <= '0;
      armed_q   <= 1'b0;
      seizure_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_run_q  <= on_run_d;
      off_run_q <= off_run_d;
      base_q    <= base_d;
      armed_q   <= armed_d;
      seizure_q <= seizure_d;
    end
  end

  assign seizure = seizure_q;
  assign armed   = armed_q;

`ifdef SEIZURE_EVENT_COUNT_EN
  logic [15:0] evt_q, evt_d;
  logic        onset;

  // Only fresh onsets count; CLEARING -> ALARM is the same episode.
  assign onset = ((state_q == IDLE) || (state_q == PENDING)) && (state_d == ALARM);
  assign evt_d = (onset && (evt_q != 16'hFFFF)) ? evt_q + 16'd1 : evt_q;

  always_ff @(posedge clk) begin
    if (rst) evt_q <= 16'd0;
    else     evt_q <= evt_d;
  end

  assign event_count = evt_q;
`else
  assign event_count = 16'd0;
`endif

endmodule

// File: tb/tb_seizure_detector.sv
// Self-checking bench for seizure_detector: directed scenarios plus randomized traffic against a streak-count model.
module tb_seizure_detector;

  localparam int ONSET  = 4;
  localparam int OFFSET = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [24:0] feat_in;
  logic               feat_valid;
  logic signed [36:0] base_in;
  logic               base_valid;
  logic               seizure, exceed, armed;
  logic [15:0]        event_count;

  always #5 clk = ~clk;

  seizure_detector dut (
    .clk        (clk),
    .rst        (rst),
    .feat_in    (feat_in),
    .feat_valid (feat_valid),
    .base_in    (base_in),
    .base_valid (base_valid),
    .seizure    (seizure),
    .exceed     (exceed),
    .armed      (armed),
    .event_count(event_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive-streak counts, alarm flag and onset tally.
  longint m_base;
  bit     m_armed, m_ex, m_sz;
  int     m_on, m_off, m_ev;
  // Expected DUT outputs just after the edge of the most recent step.
  bit     exp_sz, exp_ex, exp_armed;
  int     exp_ev;

  task automatic model_reset();
    m_base = 0; m_armed = 0; m_ex = 0; m_sz = 0;
    m_on = 0; m_off = 0; m_ev = 0;
  endtask

  task automatic model_sample(input bit ex);
    if (!m_sz) begin
      m_on = ex ? m_on + 1 : 0;
      if (m_on >= ONSET) begin
        m_sz = 1; m_ev++; m_on = 0; m_off = 0;
      end
    end else begin
      m_off = ex ? 0 : m_off + 1;
      if (m_off >= OFFSET) begin
        m_sz = 0; m_off = 0; m_on = 0;
      end
    end
  endtask

  // One clock cycle of stimulus; outputs are stable when this returns (#1 after the edge).
  task automatic step(input int f, input bit fv, input longint b, input bit bv);
    @(negedge clk);
    feat_in = 25'(f); feat_valid = fv; base_in = 37'(b); base_valid = bv;
    exp_sz = m_sz;
`ifdef SEIZURE_EVENT_COUNT_EN
    exp_ev = m_ev;
`else
    exp_ev = 0;
`endif
    if (fv) begin
      m_ex = (longint'(f) * 16) > (m_base * 48);
      if (m_armed || bv) model_sample(m_ex);
    end
    if (bv) begin
      m_base  = (b < 16) ? 16 : b;
      m_armed = 1;
    end
    exp_ex = m_ex; exp_armed = m_armed;
    @(posedge clk); #1;
    feat_valid = 1'b0; base_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; feat_valid = 1'b0; base_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL reset_seizure got=%0b exp=0", seizure); end
    checks++; if (exceed !== 1'b0) begin errors++; $display("FAIL reset_exceed got=%0b exp=0", exceed); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed got=%0b exp=0", armed); end
    checks++; if (event_count !== 16'd0) begin errors++; $display("FAIL reset_evcnt got=%0d exp=0", event_count); end
  endtask

  task automatic test_warmup();
    for (int i = 0; i < 10; i++) begin
      step(100000, 1, 0, 0);
      checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL warmup_seizure i=%0d got=%0b exp=0", i, seizure); end
      checks++; if (armed !== 1'b0) begin errors++; $display("FAIL warmup_armed i=%0d got=%0b exp=0", i, armed); end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL warmup_tail got=%0b exp=0", seizure); end
  endtask

  task automatic test_onset();
    do_reset();
    step(0, 0, 1000, 1);
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL onset_armed got=%0b exp=1", armed); end
    for (int i = 0; i < 4; i++) begin
      step(3000, 1, 0, 0);
      checks++; if (exceed !== 1'b0) begin errors++; $display("FAIL onset_eq_exceed i=%0d got=%0b exp=0", i, exceed); end
    end
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL onset_eq_seizure got=%0b exp=0", seizure); end
    for (int i = 0; i < 4; i++) begin
      step(3001, 1, 0, 0);
      checks++; if (exceed !== 1'b1) begin errors++; $display("FAIL onset_gt_exceed i=%0d got=%0b exp=1", i, exceed); end
      checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL onset_early i=%0d got=%0b exp=0", i, seizure); end
    end
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b1) begin errors++; $display("FAIL onset_latency got=%0b exp=1", seizure); end
  endtask

  task automatic test_broken_run();
    int seq[8] = '{3001, 3001, 3001, 2000, 3001, 3001, 3001, 3001};
    do_reset();
    step(0, 0, 1000, 1);
    for (int i = 0; i < 7; i++) step(seq[i], 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL broken_run got=%0b exp=0", seizure); end
    step(seq[7], 1, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b1) begin errors++; $display("FAIL broken_run_onset got=%0b exp=1", seizure); end
  endtask

  // Continues from the alarm raised by test_broken_run.
  task automatic test_offset();
    for (int i = 0; i < 7; i++) step(500, 1, 0, 0);
    step(3001, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b1) begin errors++; $display("FAIL offset_reentry got=%0b exp=1", seizure); end
    for (int i = 0; i < 7; i++) step(500, 1, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b1) begin errors++; $display("FAIL offset_hold7 got=%0b exp=1", seizure); end
    step(500, 1, 0, 0);
    checks++; if (seizure !== 1'b1) begin errors++; $display("FAIL offset_early got=%0b exp=1", seizure); end
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL offset_clear got=%0b exp=0", seizure); end
  endtask

  task automatic test_floor_coincident();
    do_reset();
    step(0, 0, -5, 1);
    step(48, 1, 0, 0);
    checks++; if (exceed !== 1'b0) begin errors++; $display("FAIL floor_48 got=%0b exp=0", exceed); end
    step(49, 1, 0, 0);
    checks++; if (exceed !== 1'b1) begin errors++; $display("FAIL floor_49 got=%0b exp=1", exceed); end
    step(0, 0, 0, 0);
    checks++; if (exceed !== 1'b1) begin errors++; $display("FAIL exceed_hold got=%0b exp=1", exceed); end
    step(48, 1, 0, 0);
    checks++; if (exceed !== 1'b0) begin errors++; $display("FAIL floor_48b got=%0b exp=0", exceed); end
    step(49, 1, 1000, 1);
    checks++; if (exceed !== 1'b1) begin errors++; $display("FAIL coincident_old_base got=%0b exp=1", exceed); end
    step(49, 1, 0, 0);
    checks++; if (exceed !== 1'b0) begin errors++; $display("FAIL coincident_new_base got=%0b exp=0", exceed); end
    step(3001, 1, 0, 0);
    checks++; if (exceed !== 1'b1) begin errors++; $display("FAIL new_base_gt got=%0b exp=1", exceed); end
  endtask

  task automatic test_reset_mid_alarm();
    int exp_cnt;
    do_reset();
    step(0, 0, 1000, 1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) step(3001, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      checks++; if (seizure !== 1'b1) begin errors++; $display("FAIL rst_onset k=%0d got=%0b exp=1", k, seizure); end
      if (k < 2) begin
        for (int i = 0; i < 8; i++) step(500, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
      end
    end
`ifdef SEIZURE_EVENT_COUNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    checks++; if (event_count !== 16'(exp_cnt)) begin errors++; $display("FAIL rst_evcnt_pre got=%0d exp=%0d", event_count, exp_cnt); end
    do_reset();
    checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL rst_mid_seizure got=%0b exp=0", seizure); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL rst_mid_armed got=%0b exp=0", armed); end
    checks++; if (event_count !== 16'd0) begin errors++; $display("FAIL rst_mid_evcnt got=%0d exp=0", event_count); end
    for (int i = 0; i < 5; i++) step(100000, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (seizure !== 1'b0) begin errors++; $display("FAIL rst_mid_warmup got=%0b exp=0", seizure); end
  endtask

  task automatic test_random();
    bit hi = 0;
    int f;
    longint b;
    bit fv, bv;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) hi = ~hi;
      bv = (i == 3) || ($urandom_range(0, 59) == 0);
      b  = longint'($urandom_range(0, 3000)) - 100;
      fv = ($urandom_range(0, 3) != 0);
      if ((hi ^ ($urandom_range(0, 9) == 0)) != 0)
        f = int'(m_base * 3) + int'($urandom_range(1, 200));
      else
        f = int'(m_base * 3) - int'($urandom_range(0, 200));
      step(f, fv, b, bv);
      checks++; if (seizure !== exp_sz) begin errors++; $display("FAIL rnd_seizure i=%0d got=%0b exp=%0b", i, seizure, exp_sz); end
      checks++; if (exceed !== exp_ex) begin errors++; $display("FAIL rnd_exceed i=%0d got=%0b exp=%0b", i, exceed, exp_ex); end
      checks++; if (armed !== exp_armed) begin errors++; $display("FAIL rnd_armed i=%0d got=%0b exp=%0b", i, armed, exp_armed); end
      checks++; if (event_count !== 16'(exp_ev)) begin errors++; $display("FAIL rnd_evcnt i=%0d got=%0d exp=%0d", i, event_count, exp_ev); end
    end
  endtask

  initial begin
    rst = 1'b1; feat_in = '0; feat_valid = 1'b0; base_in = '0; base_valid = 1'b0;
    model_reset();
    exp_sz = 0; exp_ex = 0; exp_armed = 0; exp_ev = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_warmup();
    test_onset();
    test_broken_run();
    test_offset();
    test_floor_coincident();
    test_reset_mid_alarm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seizure_detector.md
Name: seizure_detector

Overview:
- Consumes the long-term baseline of a feature (e.g. line length) and the per-window short-term value of the same feature.
- Flags a seizure when the short-term feature exceeds a programmable multiple of the baseline for ONSET_COUNT consecutive samples.
- Clears the flag after OFFSET_COUNT consecutive samples at or below the threshold.
- Sits directly downstream of the baseline averaging stage; its output drives the stimulation/alert logic.

Parameters:
- FEAT_WIDTH, 25, width of the signed short-term feature.
- BASE_WIDTH, 37, width of the baseline input, interpreted as signed.
- MULT_WIDTH, 8, width of the unsigned threshold multiplier, Q4.4 format.
- THRESH_MULT, 48, multiplier in Q4.4 (48 = 3.0).
- BASE_FLOOR, 16, minimum baseline value used in the comparison.
- ONSET_COUNT, 4, consecutive exceedances required to raise the alarm (range 1..255).
- OFFSET_COUNT, 8, consecutive non-exceedances required to clear the alarm (range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- feat_in  in  FEAT_WIDTH  signed short-term feature
- feat_valid  in  1  feat_in is valid this cycle; single-cycle pulse per sample
- base_in  in  BASE_WIDTH  baseline value
- base_valid  in  1  base_in is valid this cycle
- seizure  out  1  alarm flag
- exceed  out  1  registered compare result of the most recent feature sample
- armed  out  1  a baseline has been captured since reset
- event_count  out  16  number of alarm onsets (see Optional Feature)

Behaviour:
- Reset: rst and clk are as already decided (reset rst, synchronous, active-high; clock clk). On reset:
  - seizure=0, exceed=0, armed=0, event_count=0.
  - Baseline register = 0, both run counters = 0, state = WARMUP.
  - rst has priority over every other event, including mid-ALARM.
- Baseline capture: on base_valid, base_reg <= max(base_in, BASE_FLOOR) as a signed compare; armed <= 1 on the same edge.
- Same-cycle capture and sample: if base_valid and feat_valid coincide, the comparison uses the base_reg value from before the update.
- Compare stage (1 cycle): on feat_valid, compute lhs = sign-extended feat_in << 4 and rhs = base_reg * THRESH_MULT.
  - Both operands are sign-extended to BASE_WIDTH+MULT_WIDTH+1 bits; there is no truncation.
  - exceed <= (lhs > rhs), strict. exceed holds between samples.
  - cmp_valid pulses one cycle after feat_valid.
- FSM advances only on cmp_valid:
  - WARMUP: ignores all samples. Moves to IDLE on the cycle armed becomes 1.
  - IDLE: on exceed, run=1. If ONSET_COUNT==1, go to ALARM; otherwise go to PENDING.
  - PENDING: on exceed, run++. When run reaches ONSET_COUNT, go to ALARM. On !exceed, run=0 and go to IDLE.
  - ALARM: seizure=1. On !exceed, run=1; go to CLEARING, or straight to IDLE if OFFSET_COUNT==1.
  - CLEARING: seizure stays 1. On !exceed, run++; when run reaches OFFSET_COUNT, go to IDLE and seizure=0. On exceed, run=0 and return to ALARM.
- Latency: seizure rises/falls on the 2nd clk edge after the feat_valid that completes the run (compare + FSM register).
- Back-to-back feat_valid on consecutive cycles is supported at full rate.
- base_valid while in ALARM, PENDING or CLEARING updates the threshold for subsequent samples only; the state is unchanged.
- Run counters are 8-bit and saturate; they cannot wrap because of the range limits on ONSET_COUNT/OFFSET_COUNT.

Optional Feature:
- Macro: SEIZURE_EVENT_COUNT_EN.
- Defined: event_count increments, saturating at 16'hFFFF, on every IDLE/PENDING -> ALARM transition. Re-entry from CLEARING does not count.
- Undefined: event_count is tied to 0 and no counter flops are synthesised.

Decomposition:
- Package seizure_pkg holds:
  - state enum: WARMUP, IDLE, PENDING, ALARM, CLEARING.
  - Q4.4 fraction-bit constant (4).
  - Default width constants (25, 37, 8).
  - Compare-width function (BASE_WIDTH+MULT_WIDTH+1).
- One sub-module, thresh_cmp: the registered scale-and-compare, producing exceed and cmp_valid. The FSM and counters live in the top.

Test Plan:
- WARMUP hold: 10 feat_valid pulses with feat_in=100000 and no base_valid -> seizure=0, armed=0 throughout.
- Strict threshold, onset: base_in=1000 captured, then 4 samples feat_in=3000 -> exceed=0, seizure=0. Then 4 samples of 3001 -> seizure=1 exactly 2 cycles after the 4th valid.
- Broken run: baseline 1000; samples 3001, 3001, 3001, 2000, 3001 x3 -> seizure stays 0. One more 3001 -> seizure=1.
- Offset hysteresis: in ALARM, 7 samples of 500 then one of 3001 -> seizure stays 1 and state returns to ALARM. Then 8 samples of 500 -> seizure=0 two cycles after the 8th.
- Floor and coincident update: base_in=-5 -> base_reg=16, so feat_in=49 gives exceed=1. In the same cycle as a feat_valid, base_valid with base_in=1000 -> that sample still compares against 16.
- Reset mid-ALARM: assert rst for 1 cycle -> next cycle seizure=0, armed=0, event_count=0, state=WARMUP. With SEIZURE_EVENT_COUNT_EN defined, 3 onsets before the reset -> event_count=3.
